// File: rtl/uart_pkg.sv
// Shared UART defaults and a sizing helper used by the baud-rate generator.
// Defaults: 16-bit divider, 4-bit fraction, 16x oversampling.
package uart_pkg;

  localparam int UART_CNT_W  = 16;
  localparam int UART_FRAC_W = 4;
  localparam int UART_OVS    = 16;

  // Width of a modulo-ovs counter; one bit minimum so OVS=1 still elaborates.
  function automatic int ovs_cnt_w(input int ovs);
    return (ovs > 1) ? $clog2(ovs) : 1;
  endfunction

endpackage

// File: rtl/uart_baudgen_frac_if.sv
// Control/tick bundle between the UART register file (master) and the baud generator (slave).
interface uart_baudgen_frac_if
  import uart_pkg::*;
#(
  parameter int CNT_W  = UART_CNT_W,
  parameter int FRAC_W = UART_FRAC_W
);

  logic              CE;
  logic              CLEAR;
  logic              DIV_LOAD;
  logic [CNT_W-1:0]  DIV_INT;
  logic [FRAC_W-1:0] DIV_FRAC;
  logic              SYNC;
  logic              OVS_TICK;
  logic              BIT_TICK;
  logic              DIV_ACTIVE;

  modport master (
    output CE, CLEAR, DIV_LOAD, DIV_INT, DIV_FRAC, SYNC,
    input  OVS_TICK, BIT_TICK, DIV_ACTIVE
  );

  modport slave (
    input  CE, CLEAR, DIV_LOAD, DIV_INT, DIV_FRAC, SYNC,
    output OVS_TICK, BIT_TICK, DIV_ACTIVE
  );

endinterface

// File: rtl/uart_ovs_counter.sv
// Modulo-OVS oversample counter; BIT_TICK_NXT is combinational, registered by the parent.
// Advances only on CE_TICK; SYNC/CLEAR force phase 0 and suppress the coincident bit tick.
module uart_ovs_counter
  import uart_pkg::*;
#(
  parameter int OVS = UART_OVS
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE_TICK,
  input  logic CLEAR,
  input  logic SYNC,
  output logic BIT_TICK_NXT
);

  localparam int            OW   = ovs_cnt_w(OVS);
  localparam logic [OW-1:0] LAST = OW'(OVS - 1);

  logic [OW-1:0] ovs_cnt;
  logic          wrap;

  assign wrap         = (ovs_cnt == LAST);
  assign BIT_TICK_NXT = CE_TICK && wrap && !SYNC && !CLEAR;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovs_cnt <= '0;
    end else if (CLEAR || SYNC) begin
      ovs_cnt <= '0;
    end else if (CE_TICK) begin
      ovs_cnt <= wrap ? '0 : ovs_cnt + OW'(1);
    end
  end

endmodule

// File: rtl/uart_baudgen_frac.sv
// Fractional baud generator: OVS_TICK every DIV_INT(+1) CE cycles, BIT_TICK every OVS ticks.
// Ticks are registered one cycle after the terminal count; CE=0 freezes all counting.
module uart_baudgen_frac
  import uart_pkg::*;
#(
  parameter int CNT_W  = UART_CNT_W,
  parameter int FRAC_W = UART_FRAC_W,
  parameter int OVS    = UART_OVS
) (
  input  logic                CLK,
  input  logic                RST,
  uart_baudgen_frac_if.slave  bus
);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  pend_int;
  logic [CNT_W-1:0]  act_int;
  logic [CNT_W-1:0]  new_int;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] pend_frac;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] new_frac;
  logic [FRAC_W:0]   acc_sum;
  logic              carry;
  logic              term;
  logic              bit_tick_nxt;
  logic              ovs_tick_q;
  logic              bit_tick_q;

  // A load landing on the same edge as a reload is applied directly.
  assign new_int  = bus.DIV_LOAD ? bus.DIV_INT  : pend_int;
  assign new_frac = bus.DIV_LOAD ? bus.DIV_FRAC : pend_frac;

  assign term    = bus.CE && (cnt == '0) && (act_int != '0) && !bus.CLEAR;
  assign acc_sum = {1'b0, acc} + {1'b0, act_frac};
  assign carry   = acc_sum[FRAC_W];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      acc        <= '0;
      pend_int   <= '0;
      pend_frac  <= '0;
      act_int    <= '0;
      act_frac   <= '0;
      ovs_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      ovs_tick_q <= term;
      bit_tick_q <= bit_tick_nxt;

      if (bus.DIV_LOAD) begin
        pend_int  <= bus.DIV_INT;
        pend_frac <= bus.DIV_FRAC;
      end

      if (bus.CLEAR) begin
        cnt      <= '0;
        acc      <= '0;
        act_int  <= new_int;
        act_frac <= new_frac;
      end else if (term) begin
        acc      <= acc_sum[FRAC_W-1:0];
        // Reloading a zero divider parks the counter at 0 and disables the generator.
        cnt      <= (new_int == '0) ? '0 : new_int - CNT_W'(1) + CNT_W'(carry);
        act_int  <= new_int;
        act_frac <= new_frac;
      end else begin
        if (act_int == '0) begin
          act_int  <= new_int;
          act_frac <= new_frac;
        end
        if (bus.CE && (cnt != '0)) begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  uart_ovs_counter #(
    .OVS (OVS)
  ) u_ovs (
    .CLK          (CLK),
    .RST          (RST),
    .CE_TICK      (term),
    .CLEAR        (bus.CLEAR),
    .SYNC         (bus.SYNC),
    .BIT_TICK_NXT (bit_tick_nxt)
  );

  assign bus.OVS_TICK   = ovs_tick_q;
  assign bus.BIT_TICK   = bit_tick_q;
  assign bus.DIV_ACTIVE = (act_int != '0);

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Scoreboard bench for uart_baudgen_frac: stimulus queues expected tick cycles, a monitor pops them.
module tb_uart_baudgen_frac;
  import uart_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int cyc;
    bit bt;
  } exp_t;

  exp_t sb[$];

  uart_baudgen_frac_if #(.CNT_W(UART_CNT_W), .FRAC_W(UART_FRAC_W)) bus ();

  uart_baudgen_frac #(
    .CNT_W  (UART_CNT_W),
    .FRAC_W (UART_FRAC_W),
    .OVS    (UART_OVS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial forever #5 CLK = ~CLK;

  // Edge counter: after posedge n, cyc == n.
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every tick the DUT emits must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.OVS_TICK === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: OVS_TICK=1 at cycle %0d, required no tick", cyc);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.bt != bus.BIT_TICK) begin
            errors++;
            $display("FAIL tick_match: got tick at cycle %0d BIT_TICK=%0b, required cycle %0d BIT_TICK=%0b",
                     cyc, bus.BIT_TICK, e.cyc, e.bt);
          end
        end
      end else if (bus.BIT_TICK !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL bit_without_ovs: BIT_TICK=%0b OVS_TICK=%0b at cycle %0d, required BIT_TICK=0",
                 bus.BIT_TICK, bus.OVS_TICK, cyc);
      end
    end
  end

  task automatic push(input int c, input bit b);
    sb.push_back('{c, b});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic end_test(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected ticks never seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    bus.CE       = 1'b0;
    bus.CLEAR    = 1'b0;
    bus.DIV_LOAD = 1'b0;
    bus.SYNC     = 1'b0;
    bus.DIV_INT  = '0;
    bus.DIV_FRAC = '0;
    repeat (2) @(negedge CLK);
    chk("rst_ovs_tick", int'(bus.OVS_TICK), 0);
    chk("rst_bit_tick", int'(bus.BIT_TICK), 0);
    chk("rst_div_active", int'(bus.DIV_ACTIVE), 0);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  // Inputs set at negedge with cyc==c are captured at edge c+1.
  task automatic load(input int di, input int df);
    bus.DIV_LOAD = 1'b1;
    bus.DIV_INT  = UART_CNT_W'(di);
    bus.DIV_FRAC = UART_FRAC_W'(df);
    @(negedge CLK);
    bus.DIV_LOAD = 1'b0;
  endtask

  initial begin
    int c0;
    int t;

    do_reset();

    // 1: DIV_INT=4 -> tick every 4, BIT_TICK on every 16th tick.
    c0 = cyc;
    bus.CE = 1'b1;
    for (int k = 0; k < 36; k++) push(c0 + 2 + 4*k, (k % 16) == 15);
    load(4, 0);
    chk("t1_div_active", int'(bus.DIV_ACTIVE), 1);
    wait_cyc(c0 + 143);
    end_test("t1_pending");
    do_reset();

    // 2: 3.5 divider -> intervals 3,4,3,4...; 16 ticks span 56 cycles.
    c0 = cyc;
    bus.CE = 1'b1;
    t = c0 + 2;
    for (int k = 0; k < 33; k++) begin
      push(t, (k % 16) == 15);
      t += ((k % 2) == 0) ? 3 : 4;
    end
    load(3, 8);
    wait_cyc(c0 + 115);
    end_test("t2_pending");
    do_reset();

    // 3: CE toggling -> tick every 8; CE held low for edges c0+77..c0+96 freezes the count.
    c0 = cyc;
    for (int k = 0; k < 10; k++) push(c0 + 3 + 8*k, 1'b0);
    for (int j = 0; j < 6; j++) push(c0 + 103 + 8*j, j == 5);
    bus.DIV_INT  = UART_CNT_W'(4);
    bus.DIV_FRAC = '0;
    for (int e = c0 + 1; e <= c0 + 145; e++) begin
      bus.CE       = (((e - c0) % 2) == 1) && !(e >= c0 + 77 && e <= c0 + 96);
      bus.DIV_LOAD = (e == c0 + 1);
      @(negedge CLK);
    end
    bus.DIV_LOAD = 1'b0;
    end_test("t3_pending");
    do_reset();

    // 4: running /10, load 2 three cycles after a tick, then load 0 on a reload edge.
    c0 = cyc;
    bus.CE = 1'b1;
    push(c0 + 2, 1'b0);
    push(c0 + 12, 1'b0);
    for (int k = 0; k < 6; k++) push(c0 + 22 + 2*k, 1'b0);
    load(10, 0);
    wait_cyc(c0 + 14);
    load(2, 0);
    wait_cyc(c0 + 31);
    chk("t4_active_before_stop", int'(bus.DIV_ACTIVE), 1);
    load(0, 0);
    chk("t4_active_after_stop", int'(bus.DIV_ACTIVE), 0);
    wait_cyc(c0 + 60);
    chk("t4_active_idle", int'(bus.DIV_ACTIVE), 0);
    end_test("t4_pending");

    // 5: DIV_INT=1 -> tick every cycle; the 8 ticks of test 4 left the oversample phase at 8.
    c0 = cyc;
    for (int k = 0; k < 20; k++) push(c0 + 2 + k, k == 7);
    load(1, 0);
    wait_cyc(c0 + 21);
    end_test("t5_pending");
    do_reset();

    // 6: SYNC at phase 7 realigns; SYNC on the phase-15 tick suppresses that BIT_TICK.
    c0 = cyc;
    bus.CE = 1'b1;
    for (int k = 0; k < 55; k++) push(c0 + 2 + 2*k, (k == 22) || (k == 54));
    load(2, 0);
    wait_cyc(c0 + 14);
    bus.SYNC = 1'b1;
    @(negedge CLK);
    bus.SYNC = 1'b0;
    wait_cyc(c0 + 77);
    bus.SYNC = 1'b1;
    @(negedge CLK);
    bus.SYNC = 1'b0;
    wait_cyc(c0 + 111);
    end_test("t6_pending");
    do_reset();

    // 7: CLEAR at cnt=5 with acc=8 restarts counter, accumulator and phase.
    c0 = cyc;
    bus.CE = 1'b1;
    push(c0 + 2, 1'b0);
    push(c0 + 10, 1'b0);
    t = c0 + 14;
    for (int j = 0; j < 16; j++) begin
      push(t, j == 15);
      t += ((j % 4) == 3) ? 9 : 8;
    end
    load(8, 4);
    wait_cyc(c0 + 12);
    bus.CLEAR = 1'b1;
    @(negedge CLK);
    bus.CLEAR = 1'b0;
    chk("t7_clear_ovs_tick", int'(bus.OVS_TICK), 0);
    chk("t7_clear_active", int'(bus.DIV_ACTIVE), 1);
    wait_cyc(c0 + 139);
    end_test("t7_pending");

    // RST mid-period: divider registers cleared, generator stays silent.
    do_reset();
    bus.CE = 1'b1;
    repeat (30) @(negedge CLK);
    chk("post_rst_active", int'(bus.DIV_ACTIVE), 0);
    end_test("post_rst_pending");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
